// File: rtl/operand_entry_fsm.sv
// rtl/operand_entry_fsm.sv - push-button debounce and operand entry sequencer for the 4-bit calculator
module operand_entry_fsm #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw,
    input  logic       sub_sw,
    input  logic       btn,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic       s,
    output logic       result_valid,
    output logic [1:0] phase
);

    // Counter must reach DEBOUNCE_CYCLES-1; keep at least one bit for tiny settings.
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    // Phase encoding doubles as the FSM state so the status LEDs come straight off the state flops.
    localparam logic [1:0] LOAD_A = 2'b00;
    localparam logic [1:0] LOAD_B = 2'b01;
    localparam logic [1:0] SHOW   = 2'b10;

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          db_q, db_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          db_prev_q, db_prev_d;
    logic          press;

    logic [1:0]    phase_q, phase_d;
    logic [3:0]    a_q, a_d;
    logic [3:0]    b_q, b_d;
    logic          s_q, s_d;
    logic          rv_q, rv_d;

    // Two-flop synchroniser for the asynchronous button.
    always_comb begin
        sync1_d = btn;
        sync2_d = sync1_q;
    end

    // Debounce: the synchronised level must differ from db for DEBOUNCE_CYCLES straight cycles to flip it.
    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        if (sync2_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            db_d  = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Rising edge of the debounced level is the only event; releases are ignored.
    always_comb begin
        db_prev_d = db_q;
        press     = db_q & ~db_prev_q;
    end

    // Entry sequencer: capture A, then B with the operation, then clear for the next calculation.
    always_comb begin
        phase_d = phase_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        rv_d    = rv_q;
        case (phase_q)
            LOAD_A: begin
                if (press) begin
                    a_d     = sw;
                    phase_d = LOAD_B;
                end
            end
            LOAD_B: begin
                if (press) begin
                    b_d     = sw;
                    s_d     = sub_sw;
                    rv_d    = 1'b1;
                    phase_d = SHOW;
                end
            end
            SHOW: begin
                if (press) begin
                    a_d     = 4'd0;
                    b_d     = 4'd0;
                    s_d     = 1'b0;
                    rv_d    = 1'b0;
                    phase_d = LOAD_A;
                end
            end
            default: begin
                // Unreachable encoding: recover to a clean LOAD_A without waiting for a press.
                a_d     = 4'd0;
                b_d     = 4'd0;
                s_d     = 1'b0;
                rv_d    = 1'b0;
                phase_d = LOAD_A;
            end
        endcase
    end

    // Button path registers; reset drops any debounce in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            db_q      <= 1'b0;
            cnt_q     <= '0;
            db_prev_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            db_q      <= db_d;
            cnt_q     <= cnt_d;
            db_prev_q <= db_prev_d;
        end
    end

    // Sequencer state and captured operands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= LOAD_A;
            a_q     <= 4'd0;
            b_q     <= 4'd0;
            s_q     <= 1'b0;
            rv_q    <= 1'b0;
        end else begin
            phase_q <= phase_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            rv_q    <= rv_d;
        end
    end

    // Outputs are taken directly from flops so the downstream adder/display sees no input glitches.
    always_comb begin
        a            = a_q;
        b            = b_q;
        s            = s_q;
        result_valid = rv_q;
        phase        = phase_q;
    end

endmodule
